// File: rtl/seg7_scanner_if.sv
// Display-side bus of the 7-segment scanner: BCD load port in, pin drive out.
interface seg7_scanner_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value_bcd;
   logic                load;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   an;
   logic                frame_done;

   modport master (
      output value_bcd, load,
      input  seg, an, frame_done
   );

   modport slave (
      input  value_bcd, load,
      output seg, an, frame_done
   );
endinterface

// File: rtl/seg7_scanner.sv
// Time-multiplexed common-anode 7-segment driver. Loads are shadowed and
// committed only at the frame boundary so a digit never tears mid-scan.
module seg7_scanner #(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int GUARD         = 2,
   parameter int BLANK_LEADING = 1,
   parameter int ACTIVE_LOW    = 1
) (
   input logic           clk,
   input logic           rst,
   seg7_scanner_if.slave bus
);
   localparam int DW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] GUARD_END = DW'(GUARD);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
   localparam logic          POL       = (ACTIVE_LOW != 0);

   logic [DW-1:0]         div_cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   pending;
   logic [4*DIGITS-1:0]   active;
   logic                  pend;
   logic                  boundary;
   logic [3:0]            nib;
   logic [DIGITS-1:0]     lz;
   logic [6:0]            seg_int;
   logic [DIGITS-1:0]     an_int;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h40;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   always_comb begin
      logic zrun;
      boundary = (div_cnt == DIV_LAST) && (idx == IDX_LAST);
      nib      = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) nib = active[4*k +: 4];
      end
      // lz[k]: nibbles k..DIGITS-1 are all zero ('-' counts as nonzero)
      zrun = 1'b1;
      lz   = '0;
      for (int unsigned k = DIGITS; k > 0; k--) begin
         zrun    = zrun & (active[4*(k-1) +: 4] == 4'h0);
         lz[k-1] = zrun;
      end
      seg_int = '0;
      an_int  = '0;
      if (div_cnt >= GUARD_END) begin
         an_int[idx] = 1'b1;
         if (!((BLANK_LEADING != 0) && (idx != '0) && lz[idx])) seg_int = decode(nib);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt        <= '0;
         idx            <= '0;
         pending        <= '0;
         pend           <= 1'b0;
         active         <= '0;
         bus.frame_done <= 1'b0;
         bus.an         <= {DIGITS{POL}};
         bus.seg        <= {7{POL}};
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         if (div_cnt == DIV_LAST) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         // A load landing on the boundary bypasses the shadow register
         if (boundary) begin
            if (bus.load)  active <= bus.value_bcd;
            else if (pend) active <= pending;
            pend <= 1'b0;
         end else if (bus.load) begin
            pending <= bus.value_bcd;
            pend    <= 1'b1;
         end
         bus.frame_done <= boundary;
         bus.an         <= an_int ^ {DIGITS{POL}};
         bus.seg        <= seg_int ^ {7{POL}};
      end
   end
endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner: frame-position reference model plus directed
// scenarios and a randomized anode-safety run.
module tb_seg7_scanner;
   localparam int D  = 4;
   localparam int R  = 8;
   localparam int G  = 2;
   localparam int FR = D * R;
   localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   seg7_scanner_if #(.DIGITS(D)) bus ();
   seg7_scanner_if #(.DIGITS(D)) bus_nb ();
   assign bus_nb.value_bcd = bus.value_bcd;
   assign bus_nb.load      = bus.load;

   seg7_scanner #(.DIGITS(D), .REFRESH_DIV(R), .GUARD(G), .BLANK_LEADING(1), .ACTIVE_LOW(1))
      dut (.clk(clk), .rst(rst), .bus(bus));
   seg7_scanner #(.DIGITS(D), .REFRESH_DIV(R), .GUARD(G), .BLANK_LEADING(0), .ACTIVE_LOW(1))
      dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

   // Reference model: n = clock edges since reset release, frame position = n mod FR
   int unsigned n          = 0;
   logic [15:0] m_active   = '0;
   logic [15:0] m_pending  = '0;
   logic        m_pend     = 1'b0;
   logic [3:0]  exp_an     = 4'hF;
   logic [6:0]  exp_seg    = 7'h7F;
   logic [6:0]  exp_seg_nb = 7'h7F;
   logic        exp_fd     = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      int unsigned p, slot, off;
      logic [3:0]  d;
      if (rst) begin
         n = 0; m_active = '0; m_pending = '0; m_pend = 1'b0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_seg_nb = 7'h7F; exp_fd = 1'b0;
      end else begin
         p = n % FR; slot = p / R; off = p % R;
         exp_fd = (p == FR - 1);
         if (off < G) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_seg_nb = 7'h7F;
         end else begin
            exp_an     = ~(4'b0001 << slot);
            d          = 4'((m_active >> (4 * slot)) & 16'hF);
            exp_seg_nb = ~FONT[d];
            exp_seg    = (slot > 0 && (m_active >> (4 * slot)) == 16'd0) ? 7'h7F : ~FONT[d];
         end
         if (p == FR - 1) begin
            if (bus.load)    m_active = bus.value_bcd;
            else if (m_pend) m_active = m_pending;
            m_pend = 1'b0;
         end else if (bus.load) begin
            m_pending = bus.value_bcd;
            m_pend    = 1'b1;
         end
         n = n + 1;
      end
   end

   task automatic wait_pos(input int unsigned p);
      for (int i = 0; i < 2 * FR; i++) begin
         if (n % FR == p) return;
         @(negedge clk);
      end
      vectors++; miscompares++;
      $display("FAIL wait_pos: position %0d not reached, now %0d", p, n % FR);
   endtask

   task automatic pulse_load(input logic [15:0] v);
      bus.value_bcd = v;
      bus.load      = 1'b1;
      @(negedge clk);
      bus.load      = 1'b0;
   endtask

   task automatic test_reset;
      int unsigned off, slot;
      logic [3:0] ea;
      logic [6:0] es, esn;
      rst = 1'b1; bus.load = 1'b0; bus.value_bcd = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.an, bus.seg, bus.frame_done} !== {4'hF, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0",
                  bus.an, bus.seg, bus.frame_done);
      end
      rst = 1'b0;
      for (int c = 1; c <= FR; c++) begin
         @(negedge clk);
         off = (c - 1) % R; slot = (c - 1) / R;
         ea  = (off < G) ? 4'hF : ~(4'b0001 << slot);
         es  = (off >= G && slot == 0) ? ~7'h3F : 7'h7F;
         esn = (off >= G) ? ~7'h3F : 7'h7F;
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg, bus.frame_done} !== {ea, es, esn, (c == FR)}) begin
            miscompares++;
            $display("FAIL first_frame c=%0d: an=%b seg=%h nb=%h fd=%b, want an=%b seg=%h nb=%h fd=%b",
                     c, bus.an, bus.seg, bus_nb.seg, bus.frame_done, ea, es, esn, (c == FR));
         end
      end
   endtask

   task automatic test_load_commit;
      logic [6:0] want [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
      logic got = 1'b0;
      int unsigned off, slot;
      logic [3:0] ea;
      logic [6:0] es;
      wait_pos(13);
      pulse_load(16'h1234);
      for (int i = 0; i < 2 * FR && !got; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg, bus.frame_done} !== {exp_an, exp_seg, exp_seg_nb, exp_fd}) begin
            miscompares++;
            $display("FAIL commit_hold: an=%b seg=%h nb=%h fd=%b, want an=%b seg=%h nb=%h fd=%b",
                     bus.an, bus.seg, bus_nb.seg, bus.frame_done, exp_an, exp_seg, exp_seg_nb, exp_fd);
         end
         got = bus.frame_done;
      end
      if (!got) begin
         vectors++; miscompares++;
         $display("FAIL commit_timeout: frame_done=0, want 1 within %0d cycles", 2 * FR);
      end
      for (int c = 1; c <= FR; c++) begin
         @(negedge clk);
         off = (c - 1) % R; slot = (c - 1) / R;
         ea  = (off < G) ? 4'hF : ~(4'b0001 << slot);
         es  = (off < G) ? 7'h7F : ~want[slot];
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg} !== {ea, es, es}) begin
            miscompares++;
            $display("FAIL commit_frame c=%0d: an=%b seg=%h nb=%h, want an=%b seg=%h",
                     c, bus.an, bus.seg, bus_nb.seg, ea, es);
         end
      end
   endtask

   task automatic test_last_wins;
      logic [6:0] want [4]    = '{7'h07, 7'h00, 7'h00, 7'h00};
      logic [6:0] want_nb [4] = '{7'h07, 7'h3F, 7'h3F, 7'h3F};
      logic got = 1'b0;
      int unsigned off, slot;
      logic [3:0] ea;
      logic [6:0] es, esn;
      wait_pos(3);
      pulse_load(16'h0042);
      wait_pos(10);
      pulse_load(16'h0007);
      for (int i = 0; i < 2 * FR && !got; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg, bus.frame_done} !== {exp_an, exp_seg, exp_seg_nb, exp_fd}) begin
            miscompares++;
            $display("FAIL last_wins_hold: an=%b seg=%h nb=%h fd=%b, want an=%b seg=%h nb=%h fd=%b",
                     bus.an, bus.seg, bus_nb.seg, bus.frame_done, exp_an, exp_seg, exp_seg_nb, exp_fd);
         end
         got = bus.frame_done;
      end
      if (!got) begin
         vectors++; miscompares++;
         $display("FAIL last_wins_timeout: frame_done=0, want 1 within %0d cycles", 2 * FR);
      end
      for (int c = 1; c <= FR; c++) begin
         @(negedge clk);
         off = (c - 1) % R; slot = (c - 1) / R;
         ea  = (off < G) ? 4'hF : ~(4'b0001 << slot);
         es  = (off < G) ? 7'h7F : ~want[slot];
         esn = (off < G) ? 7'h7F : ~want_nb[slot];
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg} !== {ea, es, esn}) begin
            miscompares++;
            $display("FAIL last_wins_frame c=%0d: an=%b seg=%h nb=%h, want an=%b seg=%h nb=%h",
                     c, bus.an, bus.seg, bus_nb.seg, ea, es, esn);
         end
      end
   endtask

   task automatic test_boundary_bypass;
      logic [6:0] want [4]    = '{7'h6D, 7'h40, 7'h00, 7'h00};
      logic [6:0] want_nb [4] = '{7'h6D, 7'h40, 7'h3F, 7'h3F};
      int unsigned off, slot;
      logic [3:0] ea;
      logic [6:0] es, esn;
      wait_pos(5);
      pulse_load(16'h9999);
      wait_pos(FR - 1);
      pulse_load(16'h00A5);
      vectors++;
      if (bus.frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL bypass_fd: frame_done=%b, want 1", bus.frame_done);
      end
      for (int c = 1; c <= 2 * FR; c++) begin
         @(negedge clk);
         off = (c - 1) % R; slot = ((c - 1) % FR) / R;
         ea  = (off < G) ? 4'hF : ~(4'b0001 << slot);
         es  = (off < G) ? 7'h7F : ~want[slot];
         esn = (off < G) ? 7'h7F : ~want_nb[slot];
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg} !== {ea, es, esn}) begin
            miscompares++;
            $display("FAIL bypass_frame c=%0d: an=%b seg=%h nb=%h, want an=%b seg=%h nb=%h",
                     c, bus.an, bus.seg, bus_nb.seg, ea, es, esn);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [6:0] want [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
      logic got = 1'b0;
      int unsigned off, slot;
      logic [3:0] ea;
      logic [6:0] es;
      wait_pos(3);
      pulse_load(16'h8888);
      for (int i = 0; i < 2 * FR && !got; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
            miscompares++;
            $display("FAIL rstmid_load: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                     bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
         end
         got = bus.frame_done;
      end
      if (!got) begin
         vectors++; miscompares++;
         $display("FAIL rstmid_timeout: frame_done=0, want 1 within %0d cycles", 2 * FR);
      end
      wait_pos(17);
      pulse_load(16'h5555);
      wait_pos(20);
      vectors++;
      if (bus.an !== 4'b1011) begin
         miscompares++;
         $display("FAIL rstmid_pre: an=%b, want 1011", bus.an);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bus.an, bus.seg, bus.frame_done} !== {4'hF, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL rstmid_async: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0",
                  bus.an, bus.seg, bus.frame_done);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 2 * FR; c++) begin
         @(negedge clk);
         off = (c - 1) % R; slot = ((c - 1) % FR) / R;
         ea  = (off < G) ? 4'hF : ~(4'b0001 << slot);
         es  = (off < G) ? 7'h7F : ~want[slot];
         vectors++;
         if ({bus.an, bus.seg, bus.frame_done} !== {ea, es, (c == FR || c == 2 * FR)}) begin
            miscompares++;
            $display("FAIL rstmid_after c=%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                     c, bus.an, bus.seg, bus.frame_done, ea, es, (c == FR || c == 2 * FR));
         end
      end
   endtask

   task automatic test_random_anode;
      int unsigned inact = 0;
      logic seen_active = 1'b0;
      logic [15:0] v;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.an, bus.seg, bus_nb.seg, bus.frame_done} !== {exp_an, exp_seg, exp_seg_nb, exp_fd}) begin
            miscompares++;
            $display("FAIL random_model i=%0d: an=%b seg=%h nb=%h fd=%b, want an=%b seg=%h nb=%h fd=%b",
                     i, bus.an, bus.seg, bus_nb.seg, bus.frame_done, exp_an, exp_seg, exp_seg_nb, exp_fd);
         end
         vectors++;
         if (!$onehot0(~bus.an)) begin
            miscompares++;
            $display("FAIL random_onehot i=%0d: an=%b, want at most one low bit", i, bus.an);
         end
         if (bus.an === 4'hF) begin
            inact++;
         end else begin
            if (seen_active && inact != 0) begin
               vectors++;
               if (inact != G) begin
                  miscompares++;
                  $display("FAIL random_guard i=%0d: guard=%0d cycles, want %0d", i, inact, G);
               end
            end
            seen_active = 1'b1;
            inact = 0;
         end
         for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         bus.value_bcd = v;
         bus.load      = ($urandom_range(0, 7) == 0);
      end
      bus.load = 1'b0;
   endtask

   initial begin
      bus.load      = 1'b0;
      bus.value_bcd = '0;
      test_reset;
      test_load_commit;
      test_last_wins;
      test_boundary_bypass;
      test_reset_mid;
      test_random_anode;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
